mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Arbiter and sequencer that shares one single-ported, fixed-latency unified memory between the pipeline's fetch stage (I-side) and memory stage (D-side). It grants one requester at a time, issues a single memory command, counts the memory latency, and returns the response with a one-cycle acknowledge. It also produces the fetch and memory-stage stall requests that the hazard logic consumes.

Parameters:
DATA_WIDTH, 32, data bus width
ADDRESS_WIDTH, 32, address bus width
MEM_LATENCY, 2, cycles from o_MemReq to valid i_MemRdata; legal range 1..15

Ports:
i_CLK  in  1  clock; everything is sampled on the rising edge
i_RST  in  1  synchronous active-high reset
i_IReq  in  1  fetch read request; held until o_IAck
i_IAddr  in  ADDRESS_WIDTH  fetch address
o_IRdata  out  DATA_WIDTH  fetch read data; valid while o_IAck=1
o_IAck  out  1  one-cycle fetch completion pulse
i_DReq  in  1  data request; held until o_DAck
i_DWe  in  1  1 = write, 0 = read
i_DAddr  in  ADDRESS_WIDTH  data address
i_DWdata  in  DATA_WIDTH  write data
o_DRdata  out  DATA_WIDTH  data read result; valid while o_DAck=1
o_DAck  out  1  one-cycle data completion pulse
o_StallF  out  1  fetch stall = i_IReq & ~o_IAck (combinational)
o_StallM  out  1  memory-stage stall = i_DReq & ~o_DAck (combinational)
o_MemReq  out  1  one-cycle memory command strobe
o_MemWe  out  1  memory write enable; qualified by o_MemReq
o_MemAddr  out  ADDRESS_WIDTH  memory address
o_MemWdata  out  DATA_WIDTH  memory write data
i_MemRdata  in  DATA_WIDTH  memory read data; valid exactly MEM_LATENCY cycles after o_MemReq

Behaviour:
- Reset is synchronous and active-high on i_CLK. All registered outputs reset to 0. The FSM resets to IDLE, the counter to 0, and last_grant to I.
- FSM states:
  - IDLE: samples requests each cycle.
  - WAIT: command is outstanding.
  - RESP: acknowledge cycle.
- IDLE transitions:
  - Only D requesting: grant D.
  - Only I requesting: grant I.
  - Both requesting: grant the side not in last_grant (round-robin). After reset D wins the first tie.
  - No request: stay in IDLE.
- On a grant the block registers owner, address, we (0 for I), wdata and cnt=MEM_LATENCY, updates last_grant, and enters WAIT.
- o_MemReq=1 only in the first WAIT cycle. o_MemAddr, o_MemWe and o_MemWdata hold their latched values throughout WAIT; they are don't-care elsewhere.
- WAIT: cnt decrements each cycle. The cycle in which cnt==0 is the cycle in which i_MemRdata is valid. In that cycle the block captures i_MemRdata into the owner's rdata register and moves to RESP.
- RESP: the owner's Ack is 1 for exactly one cycle. The FSM then returns to IDLE.
- Latency, with request sampled in cycle 0 and L = MEM_LATENCY:
  - o_MemReq in cycle 1.
  - Data sampled in cycle 1+L.
  - Ack in cycle 2+L.
  - IDLE in cycle 3+L.
  - Next o_MemReq no earlier than cycle 4+L.
- Requests are ignored in WAIT and RESP. Input changes after the grant have no effect on the in-flight command.
- A requester that drops its request during WAIT: the transaction still completes, Ack still pulses, and nothing is re-issued.
- A D write still runs the full WAIT/RESP sequence and o_DAck pulses. o_DRdata keeps its previous value on writes.
- o_IRdata and o_DRdata each hold their value until the next read completion on the same side.
- At most one of o_IAck and o_DAck is high in any cycle. Neither is ever high outside RESP.
- Reset mid-transaction: the FSM goes to IDLE on the next edge. The in-flight command is abandoned, no Ack is produced, and late i_MemRdata is ignored.
- The counter is 4 bits wide. MEM_LATENCY outside 1..15 is illegal and must trigger an elaboration-time error.

Test Plan:
- Single I read, L=2: i_IAddr=0x40 requested in cycle 0 -> o_MemReq=1, o_MemAddr=0x40, o_MemWe=0 in cycle 1. Memory drives 0x1234ABCD in cycle 3 -> o_IAck=1 and o_IRdata=0x1234ABCD in cycle 4. o_StallF=1 in cycles 0-3 and 0 in cycle 4.
- Tie after reset: D write 0x100/0xDEADBEEF and I read 0x44 both requested in cycle 0 -> D command (o_MemWe=1, wdata 0xDEADBEEF) in cycle 1, o_DAck in cycle 4. I command to 0x44 in cycle 6, o_IAck in cycle 9.
- Fairness: both requesters re-assert continuously for 6 transactions -> grant order D,I,D,I,D,I. Never two consecutive grants to the same side.
- Reset in cycle 2 of an I read -> all outputs 0 from cycle 3. Data arriving in cycle 3 is ignored, no o_IAck. A new request in cycle 4 gets o_MemReq in cycle 5.
- MEM_LATENCY=1: D read 0x200 in cycle 0 -> o_MemReq in cycle 1, data 0xCAFEF00D sampled in cycle 2, o_DAck and o_DRdata=0xCAFEF00D in cycle 3.
- Request dropped: i_IReq deasserted in cycle 2 of WAIT -> o_IAck still pulses in cycle 4, then the FSM stays IDLE with no further o_MemReq.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin I/D arbiter and fixed-latency sequencer for a shared single-port memory
module mem_port_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int MEM_LATENCY   = 2
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic                     i_IReq,
  input  logic [ADDRESS_WIDTH-1:0] i_IAddr,
  output logic [DATA_WIDTH-1:0]    o_IRdata,
  output logic                     o_IAck,
  input  logic                     i_DReq,
  input  logic                     i_DWe,
  input  logic [ADDRESS_WIDTH-1:0] i_DAddr,
  input  logic [DATA_WIDTH-1:0]    i_DWdata,
  output logic [DATA_WIDTH-1:0]    o_DRdata,
  output logic                     o_DAck,
  output logic                     o_StallF,
  output logic                     o_StallM,
  output logic                     o_MemReq,
  output logic                     o_MemWe,
  output logic [ADDRESS_WIDTH-1:0] o_MemAddr,
  output logic [DATA_WIDTH-1:0]    o_MemWdata,
  input  logic [DATA_WIDTH-1:0]    i_MemRdata
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : gBadLatency
    $error("mem_port_arbiter: MEM_LATENCY must be within 1..15");
  end

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [3:0] LAT  = 4'(MEM_LATENCY);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       ownerD;
  logic       lastGrantD;
  logic       anyReq;
  logic       grantD;

  // On a tie the side that did not win last time gets the port.
  assign anyReq = i_IReq | i_DReq;
  assign grantD = i_DReq & (~i_IReq | ~lastGrantD);

  assign o_StallF = i_IReq & ~o_IAck;
  assign o_StallM = i_DReq & ~o_DAck;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      ownerD     <= 1'b0;
      lastGrantD <= 1'b0;
      o_MemReq   <= 1'b0;
      o_MemWe    <= 1'b0;
      o_MemAddr  <= '0;
      o_MemWdata <= '0;
      o_IRdata   <= '0;
      o_DRdata   <= '0;
      o_IAck     <= 1'b0;
      o_DAck     <= 1'b0;
    end else begin
      o_MemReq <= 1'b0;
      o_IAck   <= 1'b0;
      o_DAck   <= 1'b0;
      case (state)
        IDLE: begin
          if (anyReq) begin
            ownerD     <= grantD;
            lastGrantD <= grantD;
            o_MemAddr  <= grantD ? i_DAddr : i_IAddr;
            o_MemWe    <= grantD & i_DWe;
            o_MemWdata <= grantD ? i_DWdata : '0;
            cnt        <= LAT;
            o_MemReq   <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          // cnt reaches zero exactly in the cycle the memory presents read data.
          if (cnt == 4'd0) begin
            if (ownerD) begin
              if (!o_MemWe) begin
                o_DRdata <= i_MemRdata;
              end
              o_DAck <= 1'b1;
            end else begin
              o_IRdata <= i_MemRdata;
              o_IAck   <= 1'b1;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a transaction-level reference model
module tb_mem_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int L  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          iReq, dReq, dWe;
  logic [AW-1:0] iAddr, dAddr;
  logic [DW-1:0] dWdata, memRdata;
  logic [DW-1:0] o_IRdata, o_DRdata, o_MemWdata;
  logic [AW-1:0] o_MemAddr;
  logic          o_IAck, o_DAck, o_StallF, o_StallM, o_MemReq, o_MemWe;

  logic          d1Req, d1We;
  logic [AW-1:0] d1Addr;
  logic [DW-1:0] mem1Rdata;
  logic [DW-1:0] o_IRdata1, o_DRdata1, o_MemWdata1;
  logic [AW-1:0] o_MemAddr1;
  logic          o_IAck1, o_DAck1, o_StallF1, o_StallM1, o_MemReq1, o_MemWe1;

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_LATENCY(L)) dut (
    .i_CLK(clk), .i_RST(rst),
    .i_IReq(iReq), .i_IAddr(iAddr), .o_IRdata(o_IRdata), .o_IAck(o_IAck),
    .i_DReq(dReq), .i_DWe(dWe), .i_DAddr(dAddr), .i_DWdata(dWdata),
    .o_DRdata(o_DRdata), .o_DAck(o_DAck),
    .o_StallF(o_StallF), .o_StallM(o_StallM),
    .o_MemReq(o_MemReq), .o_MemWe(o_MemWe), .o_MemAddr(o_MemAddr),
    .o_MemWdata(o_MemWdata), .i_MemRdata(memRdata)
  );

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_LATENCY(1)) dut1 (
    .i_CLK(clk), .i_RST(rst),
    .i_IReq(1'b0), .i_IAddr('0), .o_IRdata(o_IRdata1), .o_IAck(o_IAck1),
    .i_DReq(d1Req), .i_DWe(d1We), .i_DAddr(d1Addr), .i_DWdata('0),
    .o_DRdata(o_DRdata1), .o_DAck(o_DAck1),
    .o_StallF(o_StallF1), .o_StallM(o_StallM1),
    .o_MemReq(o_MemReq1), .o_MemWe(o_MemWe1), .o_MemAddr(o_MemAddr1),
    .o_MemWdata(o_MemWdata1), .i_MemRdata(mem1Rdata)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic failNote(string name);
    compared++;
    mismatched++;
    $display("FAIL %s: event absent or unexpected (cycle %0d)", name, cyc);
  endtask

  typedef struct {
    int            cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;
  typedef struct {
    int            cyc;
    logic          sideD;
    logic [DW-1:0] rdata;
  } ack_t;

  cmd_t          cmdQ[$];
  ack_t          ackQ[$];
  cmd_t          cmd;
  ack_t          ack;
  int            freeAt = 0;
  bit            lastD = 0;
  int            memCyc = -1;
  logic [DW-1:0] memData = '0;
  logic [DW-1:0] expI = '0, expD = '0;
  int            holdFrom = 0, holdTo = -1;
  logic [AW-1:0] holdAddr = '0;
  logic          holdWe = 1'b0;
  bit            rstSeen = 0;
  bit            useFixed = 0;
  logic [DW-1:0] fixedData = '0;
  bit            iAckSeen = 0, dAckSeen = 0;
  bit            expAckNow, expAckD, gD;
  logic [DW-1:0] rd;
  int            mem1Cyc = -1;

  always begin
    @(posedge clk);
    #1;
    memRdata  = (cyc == memCyc) ? memData : $urandom;
    mem1Rdata = (cyc == mem1Cyc) ? 32'hCAFEF00D : $urandom;
  end

  // Monitor + reference model: one transaction at a time, each taking L+3 cycles end to end.
  always @(negedge clk) begin
    iAckSeen = o_IAck;
    dAckSeen = o_DAck;
    if (rst) begin
      cmdQ.delete();
      ackQ.delete();
      memCyc = -1;
      holdTo = -1;
      lastD = 0;
      expI = '0;
      expD = '0;
      freeAt = cyc + 1;
      rstSeen = 1;
    end else begin
      if (rstSeen) begin
        check("rstMemReq", o_MemReq, 0);
        check("rstMemWe", o_MemWe, 0);
        check("rstMemAddr", o_MemAddr, 0);
        check("rstMemWdata", o_MemWdata, 0);
        check("rstIAck", o_IAck, 0);
        check("rstDAck", o_DAck, 0);
        check("rstIRdata", o_IRdata, 0);
        check("rstDRdata", o_DRdata, 0);
        rstSeen = 0;
      end
      expAckNow = (ackQ.size() > 0) && (ackQ[0].cyc == cyc);
      expAckD   = expAckNow && ackQ[0].sideD;
      check("stallF", o_StallF, iReq && !(expAckNow && !expAckD));
      check("stallM", o_StallM, dReq && !expAckD);
      check("ackExclusive", o_IAck & o_DAck, 0);

      if (o_MemReq) begin
        if (cmdQ.size() == 0) failNote("unexpectedMemReq");
        else begin
          cmd = cmdQ.pop_front();
          check("memReqCycle", cyc, cmd.cyc);
          check("memAddr", o_MemAddr, cmd.addr);
          check("memWe", o_MemWe, cmd.we);
          if (cmd.we) check("memWdata", o_MemWdata, cmd.wdata);
        end
      end else if (cmdQ.size() > 0 && cmdQ[0].cyc <= cyc) begin
        failNote("missingMemReq");
        void'(cmdQ.pop_front());
      end
      if (cyc > holdFrom && cyc <= holdTo) begin
        check("memAddrHold", o_MemAddr, holdAddr);
        check("memWeHold", o_MemWe, holdWe);
      end

      if (o_IAck || o_DAck) begin
        if (ackQ.size() == 0) failNote("unexpectedAck");
        else begin
          ack = ackQ.pop_front();
          check("ackCycle", cyc, ack.cyc);
          check("ackSide", o_DAck, ack.sideD);
          if (ack.sideD) begin
            check("dRdata", o_DRdata, ack.rdata);
            expD = ack.rdata;
          end else begin
            check("iRdata", o_IRdata, ack.rdata);
            expI = ack.rdata;
          end
        end
      end else if (expAckNow) begin
        failNote("missingAck");
        void'(ackQ.pop_front());
      end
      if (!o_IAck) check("iRdataHold", o_IRdata, expI);
      if (!o_DAck) check("dRdataHold", o_DRdata, expD);

      if (cyc >= freeAt && (iReq || dReq)) begin
        gD = dReq && (!iReq || !lastD);
        lastD = gD;
        memData = useFixed ? fixedData : $urandom;
        useFixed = 0;
        memCyc = cyc + 1 + L;
        cmdQ.push_back('{cyc + 1, gD && dWe, gD ? dAddr : iAddr, dWdata});
        holdFrom = cyc + 1;
        holdTo = cyc + 1 + L;
        holdAddr = gD ? dAddr : iAddr;
        holdWe = gD && dWe;
        rd = (gD && dWe) ? expD : memData;
        ackQ.push_back('{cyc + 2 + L, gD, rd});
        freeAt = cyc + 3 + L;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic runUntil(bit needI, bit needD, int maxCyc);
    bit doneI, doneD;
    doneI = !needI;
    doneD = !needD;
    for (int k = 0; k < maxCyc && !(doneI && doneD); k++) begin
      step();
      if (iAckSeen && needI) begin iReq = 0; doneI = 1; end
      if (dAckSeen && needD) begin dReq = 0; doneD = 1; end
    end
    if (!(doneI && doneD)) failNote("ackTimeout");
  endtask

  int acks;
  initial begin
    rst = 1; iReq = 0; dReq = 0; dWe = 0; iAddr = '0; dAddr = '0; dWdata = '0;
    d1Req = 0; d1We = 0; d1Addr = '0;
    repeat (3) step();
    rst = 0;

    useFixed = 1; fixedData = 32'h1234ABCD;
    iReq = 1; iAddr = 32'h40;
    runUntil(1, 0, 40);
    repeat (2) step();

    rst = 1; step(); rst = 0;
    dReq = 1; dWe = 1; dAddr = 32'h100; dWdata = 32'hDEADBEEF;
    iReq = 1; iAddr = 32'h44;
    runUntil(1, 1, 60);
    repeat (2) step();

    acks = 0;
    iReq = 1; dReq = 1; dWe = 0;
    for (int k = 0; k < 200 && acks < 6; k++) begin
      step();
      if (iAckSeen) begin acks++; iAddr = $urandom; end
      if (dAckSeen) begin acks++; dAddr = $urandom; dWe = $urandom_range(0, 1); dWdata = $urandom; end
    end
    if (acks < 6) failNote("fairnessTimeout");
    iReq = 0; dReq = 0;
    repeat (3) step();

    iReq = 1; iAddr = 32'h80;
    step(); step();
    rst = 1; iReq = 0;
    step();
    rst = 0;
    step();
    iReq = 1; iAddr = 32'h84;
    runUntil(1, 0, 40);
    repeat (2) step();

    iReq = 1; iAddr = 32'h90;
    step(); step();
    iReq = 0;
    repeat (10) step();

    for (int k = 0; k < 3000; k++) begin
      step();
      rst = ($urandom_range(0, 499) == 0);
      if (iReq && iAckSeen) iReq = 0;
      if (iReq && $urandom_range(0, 15) == 0) iReq = 0;
      if (!iReq && $urandom_range(0, 2) == 0) begin iReq = 1; iAddr = $urandom; end
      else if ($urandom_range(0, 3) == 0) iAddr = $urandom;
      if (dReq && dAckSeen) dReq = 0;
      if (dReq && $urandom_range(0, 15) == 0) dReq = 0;
      if (!dReq && $urandom_range(0, 2) == 0) begin
        dReq = 1; dAddr = $urandom; dWe = $urandom_range(0, 1); dWdata = $urandom;
      end else if ($urandom_range(0, 3) == 0) dWdata = $urandom;
    end
    rst = 0; iReq = 0; dReq = 0;
    repeat (25) step();
    check("drained", cmdQ.size() + ackQ.size(), 0);

    d1Req = 1; d1We = 0; d1Addr = 32'h200;
    mem1Cyc = cyc + 2;
    @(negedge clk);
    check("l1StallM", o_StallM1, 1);
    step(); @(negedge clk);
    check("l1MemReq", o_MemReq1, 1);
    check("l1MemAddr", o_MemAddr1, 32'h200);
    check("l1MemWe", o_MemWe1, 0);
    step(); @(negedge clk);
    check("l1EarlyAck", o_DAck1, 0);
    step(); @(negedge clk);
    check("l1DAck", o_DAck1, 1);
    check("l1DRdata", o_DRdata1, 32'hCAFEF00D);
    check("l1StallMAck", o_StallM1, 0);
    check("l1NoIAck", o_IAck1, 0);
    step();
    d1Req = 0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
